// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types and constants.
// Holds the NZVC flag layout, the MEM/WB control bundle layout and the
// datapath geometry used by the EX/MEM register and its flag register.
package cpu_pkg;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ZERO_REG   = 31;

  // Architectural condition flags, MSB first: {N, Z, V, C}.
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  // MEM/WB control bundle, MSB first: {reg_write, mem_read, mem_write, mem_to_reg}.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } mem_ctrl_t;

  // Control bits that actually travel into MEM for one loaded instruction:
  // a bubble carries no control, and a write to XZR is dropped at the source.
  function automatic mem_ctrl_t qualify_ctrl(
    input logic      valid,
    input logic      rd_is_zero,
    input mem_ctrl_t ctrl
  );
    mem_ctrl_t q;
    q = valid ? ctrl : '0;
    if (rd_is_zero) begin
      q.reg_write = 1'b0;
    end
    return q;
  endfunction

endpackage

// File: rtl/flag_reg.sv
// flag_reg: 4-bit architectural NZVC register.
// Synchronous active-high reset; loads i_d when i_we is asserted, holds otherwise.
module flag_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_we,
  input  flags_t i_d,
  output flags_t o_q
);

  flags_t r_flags;

  // Flag storage: reset clears, write enable loads, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= '0;
    end else if (i_we) begin
      r_flags <= i_d;
    end
  end

  assign o_q = r_flags;

endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register of the 5-stage CPU.
// Captures the ALU result, store data, destination register and MEM/WB
// control bits, and owns the architectural NZVC flags (via flag_reg).
// Edge priority: reset > stall > flush > load.
// Build option: define EX_FLAG_FWD_EN to bypass live ALU flags onto
// cond_flags for a flag-setting instruction in EX; otherwise cond_flags
// is purely the registered flags.
module ex_mem_reg #(
  parameter int unsigned DATA_W     = cpu_pkg::DATA_W,
  parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int unsigned ZERO_REG   = cpu_pkg::ZERO_REG
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [DATA_W-1:0]     ex_result,
  input  logic                  ex_negative,
  input  logic                  ex_zero,
  input  logic                  ex_overflow,
  input  logic                  ex_carry_out,
  input  logic                  ex_set_flags,
  input  logic [DATA_W-1:0]     ex_store_data,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [3:0]            ex_ctrl,
  output logic                  mem_valid,
  output logic [DATA_W-1:0]     mem_result,
  output logic [DATA_W-1:0]     mem_store_data,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic [3:0]            mem_ctrl,
  output logic [3:0]            flags,
  output logic [3:0]            cond_flags
);

  import cpu_pkg::*;

  logic                  r_valid;
  logic [DATA_W-1:0]     r_result;
  logic [DATA_W-1:0]     r_store_data;
  logic [REG_ADDR_W-1:0] r_rd;
  mem_ctrl_t             r_ctrl;

  flags_t                w_ex_flags;
  flags_t                w_flags_q;
  flags_t                w_cond_flags;
  mem_ctrl_t             w_ex_ctrl;
  mem_ctrl_t             w_load_ctrl;
  logic                  w_rd_is_zero;
  logic                  w_load;
  logic                  w_flag_we;

  assign w_ex_flags   = '{n: ex_negative, z: ex_zero, v: ex_overflow, c: ex_carry_out};
  assign w_ex_ctrl    = mem_ctrl_t'(ex_ctrl);
  assign w_rd_is_zero = (ex_rd == REG_ADDR_W'(ZERO_REG));
  assign w_load_ctrl  = qualify_ctrl(ex_valid, w_rd_is_zero, w_ex_ctrl);

  assign w_load    = ~stall & ~flush;
  assign w_flag_we = w_load & ex_valid & ex_set_flags;

  // Pipeline register: flush bubbles valid/ctrl only, leaving the datapath
  // fields as they were so a flushed slot never toggles the wide buses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_store_data <= '0;
      r_rd         <= '0;
      r_ctrl       <= '0;
    end else if (stall) begin
      r_valid      <= r_valid;
      r_result     <= r_result;
      r_store_data <= r_store_data;
      r_rd         <= r_rd;
      r_ctrl       <= r_ctrl;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
    end else begin
      r_valid      <= ex_valid;
      r_result     <= ex_result;
      r_store_data <= ex_store_data;
      r_rd         <= ex_rd;
      r_ctrl       <= w_load_ctrl;
    end
  end

  flag_reg u_flag_reg (
    .clk   (clk),
    .reset (reset),
    .i_we  (w_flag_we),
    .i_d   (w_ex_flags),
    .o_q   (w_flags_q)
  );

`ifdef EX_FLAG_FWD_EN
  // Branch flags: bypass the live ALU flags of a flag setter in EX so a
  // following B.cond resolves without waiting for the register.
  always_comb begin
    w_cond_flags = w_flags_q;
    if (ex_valid && ex_set_flags && !flush) begin
      w_cond_flags = w_ex_flags;
    end
  end
`else
  // Branch flags: registered architectural flags only.
  always_comb begin
    w_cond_flags = w_flags_q;
  end
`endif

  assign mem_valid      = r_valid;
  assign mem_result     = r_result;
  assign mem_store_data = r_store_data;
  assign mem_rd         = r_rd;
  assign mem_ctrl       = r_ctrl;
  assign flags          = w_flags_q;
  assign cond_flags     = w_cond_flags;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Testbench for ex_mem_reg: directed scenarios followed by randomized traffic.
// A driver issues one stimulus per cycle at the falling edge and pushes the
// expected post-edge outputs and the expected pre-edge cond_flags into queues;
// two monitors pop and compare independently.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush, ex_valid;
  logic [63:0] ex_result, ex_store_data;
  logic        ex_negative, ex_zero, ex_overflow, ex_carry_out, ex_set_flags;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_ctrl;
  logic        mem_valid;
  logic [63:0] mem_result, mem_store_data;
  logic [4:0]  mem_rd;
  logic [3:0]  mem_ctrl, flags, cond_flags;

  always #5 clk = ~clk;

  ex_mem_reg #(.DATA_W(64), .REG_ADDR_W(5), .ZERO_REG(31)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_result      (ex_result),
    .ex_negative    (ex_negative),
    .ex_zero        (ex_zero),
    .ex_overflow    (ex_overflow),
    .ex_carry_out   (ex_carry_out),
    .ex_set_flags   (ex_set_flags),
    .ex_store_data  (ex_store_data),
    .ex_rd          (ex_rd),
    .ex_ctrl        (ex_ctrl),
    .mem_valid      (mem_valid),
    .mem_result     (mem_result),
    .mem_store_data (mem_store_data),
    .mem_rd         (mem_rd),
    .mem_ctrl       (mem_ctrl),
    .flags          (flags),
    .cond_flags     (cond_flags)
  );

  typedef struct packed {
    logic        valid;
    logic [63:0] result;
    logic [63:0] store;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
    logic [3:0]  flags;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic        stl;
    logic        fls;
    logic        valid;
    logic [63:0] result;
    logic        n, z, v, c;
    logic        set_flags;
    logic [63:0] store;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
  } stim_t;

  out_t        out_q[$];
  string       oname_q[$];
  logic [3:0]  cond_q[$];
  string       cname_q[$];

  out_t        model;
  logic        known = 1'b0;
  int          n_pass = 0;
  int          n_total = 0;

  // What the MEM stage should hold after one edge, straight from the rules.
  function automatic out_t model_next(input out_t cur, input stim_t s);
    out_t nx;
    nx = cur;
    if (s.rst) return '0;
    if (s.stl) return cur;
    if (s.fls) begin
      nx.valid = 1'b0;
      nx.ctrl  = 4'b0000;
      return nx;
    end
    nx.valid  = s.valid;
    nx.result = s.result;
    nx.store  = s.store;
    nx.rd     = s.rd;
    nx.ctrl   = s.valid ? s.ctrl : 4'b0000;
    if (s.rd == 5'd31) nx.ctrl = nx.ctrl & 4'b0111;
    if (s.valid && s.set_flags) nx.flags = {s.n, s.z, s.v, s.c};
    return nx;
  endfunction

  function automatic logic [3:0] expected_cond(input logic [3:0] arch, input stim_t s);
`ifdef EX_FLAG_FWD_EN
    if (s.valid && s.set_flags && !s.fls) return {s.n, s.z, s.v, s.c};
`endif
    return arch;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst       = ($urandom_range(0, 31) == 0);
    s.stl       = ($urandom_range(0, 4) == 0);
    s.fls       = ($urandom_range(0, 4) == 0);
    s.valid     = ($urandom_range(0, 3) != 0);
    s.result    = {$urandom, $urandom};
    s.store     = {$urandom, $urandom};
    s.n         = $urandom_range(0, 1) == 1;
    s.z         = $urandom_range(0, 1) == 1;
    s.v         = $urandom_range(0, 1) == 1;
    s.c         = $urandom_range(0, 1) == 1;
    s.set_flags = ($urandom_range(0, 2) == 0);
    s.rd        = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
    s.ctrl      = 4'($urandom_range(0, 15));
    return s;
  endfunction

  task automatic drive(input stim_t s, input string name);
    @(negedge clk);
    reset         = s.rst;
    stall         = s.stl;
    flush         = s.fls;
    ex_valid      = s.valid;
    ex_result     = s.result;
    ex_store_data = s.store;
    ex_negative   = s.n;
    ex_zero       = s.z;
    ex_overflow   = s.v;
    ex_carry_out  = s.c;
    ex_set_flags  = s.set_flags;
    ex_rd         = s.rd;
    ex_ctrl       = s.ctrl;
    if (known) begin
      cond_q.push_back(expected_cond(model.flags, s));
      cname_q.push_back(name);
    end
    model = model_next(model, s);
    out_q.push_back(model);
    oname_q.push_back(name);
    if (s.rst) known = 1'b1;
  endtask

  // Registered outputs, sampled just after the rising edge.
  initial begin
    out_t  exp_o, act_o;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (out_q.size() != 0) begin
        exp_o = out_q.pop_front();
        nm    = oname_q.pop_front();
        act_o = '{valid: mem_valid, result: mem_result, store: mem_store_data,
                  rd: mem_rd, ctrl: mem_ctrl, flags: flags};
        n_total++;
        if (act_o === exp_o) n_pass++;
        else $display("FAIL %s outputs: got v=%b res=%h st=%h rd=%0d ctrl=%b flags=%b, want v=%b res=%h st=%h rd=%0d ctrl=%b flags=%b",
                      nm, act_o.valid, act_o.result, act_o.store, act_o.rd, act_o.ctrl, act_o.flags,
                      exp_o.valid, exp_o.result, exp_o.store, exp_o.rd, exp_o.ctrl, exp_o.flags);
      end
    end
  end

  // Branch flags, sampled mid-cycle while the EX inputs are stable.
  initial begin
    logic [3:0] exp_c;
    string      nm;
    forever begin
      @(negedge clk);
      #2;
      if (cond_q.size() != 0) begin
        exp_c = cond_q.pop_front();
        nm    = cname_q.pop_front();
        n_total++;
        if (cond_flags === exp_c) n_pass++;
        else $display("FAIL %s cond_flags: got %b want %b", nm, cond_flags, exp_c);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    model = '0;

    // Reset held two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      s = rand_stim();
      s.rst = 1'b1;
      drive(s, "reset");
    end

    s = '0; s.valid = 1'b1; s.result = 64'h10; s.rd = 5'd5; s.ctrl = 4'b1000;
    s.store = 64'h1234;
    drive(s, "load");

    s.rd = 5'd31;
    drive(s, "xzr");

    s = '0; s.valid = 1'b1; s.result = 64'h0; s.rd = 5'd2; s.ctrl = 4'b1000;
    s.z = 1'b1; s.c = 1'b1; s.set_flags = 1'b1;
    drive(s, "subs");
    s.set_flags = 1'b0; s.n = 1'b1; s.z = 1'b0; s.v = 1'b1; s.c = 1'b0;
    s.result = 64'h6;
    drive(s, "add_noflags");

    s = '0; s.valid = 1'b1; s.result = 64'hAA; s.rd = 5'd7; s.ctrl = 4'b1001;
    drive(s, "load_A");
    s.result = 64'hBB; s.rd = 5'd8; s.stl = 1'b1; s.fls = 1'b1;
    s.set_flags = 1'b1; s.n = 1'b1;
    drive(s, "stall_flush1");
    drive(s, "stall_flush2");
    s.stl = 1'b0;
    drive(s, "flush");

    s = '0; s.valid = 1'b1; s.result = 64'hFFFF_FFFF_FFFF_FFF0; s.rd = 5'd3;
    s.set_flags = 1'b1; s.n = 1'b1; s.c = 1'b1;
    drive(s, "fwd_n");
    s.n = 1'b0; s.z = 1'b1;
    drive(s, "back2back");

    for (int i = 0; i < 400; i++) begin
      s = rand_stim();
      drive(s, "random");
    end

    s = rand_stim(); s.rst = 1'b1; s.stl = 1'b1;
    drive(s, "reset_stall");
    s = rand_stim(); s.rst = 1'b0; s.stl = 1'b0;
    drive(s, "after_reset");

    s = '0;
    drive(s, "idle");
    repeat (3) @(posedge clk);
    #3;
    if (out_q.size() != 0 || cond_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", out_q.size(), cond_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
